// File: rtl/rf_pkg.sv
// Shared types for the register-file request/select path.
// Sizes, index/one-hot types and the index-to-one-hot decode.
package rf_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] onehot_t;

  function automatic onehot_t idx_to_onehot(input idx_t idx);
    idx_to_onehot = onehot_t'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin / fixed-priority pick over eight requests.
// Rotating by ptr turns "first set bit at or after ptr" into a plain lowest-bit scan.
module rr_pick
  import rf_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  onehot_t rot_s;
  onehot_t scan_s;
  idx_t    base_s;
  idx_t    off_s;

  // Rotate, scan for the lowest set bit, then rotate the offset back.
  always_comb begin
    rot_s = onehot_t'({req, req} >> ptr);
    if (RR_EN) begin
      scan_s = rot_s;
      base_s = ptr;
    end else begin
      scan_s = req;
      base_s = '0;
    end
    off_s = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (scan_s[i]) begin
        off_s = idx_t'(i);
      end else begin
        off_s = off_s;
      end
    end
    pick = base_s + off_s;
    any  = |req;
  end

endmodule

// File: rtl/rr_encoder_8_3.sv
// Round-robin 8-to-3 request encoder with a registered ready/valid output.
// ack is combinational and fires only in the cycle a request is captured.
module rr_encoder_8_3
  import rf_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] out_onehot
);

  logic out_valid_q, out_valid_d;
  idx_t out_idx_q, out_idx_d;
  idx_t ptr_q, ptr_d;
  idx_t pick_s;
  logic any_s;
  logic load_s;

  rr_pick #(.RR_EN(RR_EN)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick_s),
    .any  (any_s)
  );

  // Capture decision, ack decode and next-state for the output register and pointer.
  always_comb begin
    load_s      = (!out_valid_q || out_ready) && any_s && reset_n;
    ack         = '0;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    ptr_d       = ptr_q;
    if (load_s) begin
      ack         = idx_to_onehot(pick_s);
      out_valid_d = 1'b1;
      out_idx_d   = pick_s;
      ptr_d       = pick_s + idx_t'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset discards any pending output and rewinds the pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_valid_q ? idx_to_onehot(out_idx_q) : '0;

endmodule
